decoder_nto2n_scan: RTL and testbench
=====================================

Name: decoder_nto2n_scan

Overview:
Parametrised successor to the team's 2-to-4 line decoder.
- Produces a registered one-hot output of 2^N lines from an N-bit select.
- Adds an autonomous scan mode that walks the lines with a programmable dwell time, for row/digit strobing of keypads and multiplexed displays.
- Sits between control logic and the strobe or select pins of such peripherals.

Parameters:
- N, 2, select width; output width is 2^N; legal range 1..6.
- DWELL_W, 8, width of the dwell counter and dwell register.
- DWELL_RST, 0, reset value of the dwell register.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  asynchronous reset, active-high.
- en  input  1  enable; when low, all output lines are driven inactive.
- mode  input  1  0 = direct decode, 1 = auto-scan.
- A  input  N  select address, used in direct mode.
- load  input  1  one-cycle strobe that captures dwell.
- dwell  input  DWELL_W  scan dwell value; period per line is dwell+1 cycles.
- D  output  2^N  registered one-hot decoder output.
- idx  output  N  binary index of the active line.
- wrap  output  1  one-cycle pulse when the scan index rolls over from 2^N-1 to 0.

Behaviour:
- Reset is asynchronous and active-high. It takes effect immediately, mid-operation included.
  - D=0, idx=0, wrap=0, dwell counter cnt=0, dwell_reg=DWELL_RST, state=IDLE.
- The FSM has three states: IDLE, DIRECT, SCAN. All outputs are registered.
- IDLE: D=0, idx holds, cnt=0.
  - If en=1 and mode=0, go to DIRECT.
  - If en=1 and mode=1, go to SCAN.
- en=0 in any state: the next edge goes to IDLE, D=0, wrap=0.
- DIRECT:
  - Each edge: D <= 1<<A, idx <= A.
  - Latency is 1 cycle from A to D; A changes are tracked every cycle.
  - If mode becomes 1, go to SCAN.
- SCAN entry, from IDLE or DIRECT: idx <= 0, D <= 1, cnt <= 0. A is ignored while in SCAN.
- SCAN steady state:
  - While cnt != dwell_reg: cnt <= cnt+1.
  - When cnt == dwell_reg: cnt <= 0, idx <= idx+1 (modulo 2^N), and D <= 1<<(idx+1), all on the same edge.
  - dwell_reg=0 advances the line every cycle.
  - Rollover from 2^N-1 to 0 sets wrap=1 for exactly one cycle. wrap is 0 otherwise.
  - If mode becomes 0, go to DIRECT; idx and D follow A on that edge.
- load, in any state: dwell_reg <= dwell.
  - In SCAN, load also forces cnt <= 0 and suppresses the advance on that edge, even if cnt == dwell_reg.
  - The new period starts on the following cycle.
- Invariant: D is always one-hot or all-zero. When D is one-hot, D[idx] is the set bit.
- Leaving SCAN and re-entering it always restarts at idx 0. The scan position is not retained.
- N=1 degenerates to a 1-to-2 decoder; scan then alternates between lines 0 and 1, with wrap on every second advance.

Optional Feature:
- Macro: DECODER_SCAN_MASK_EN.
- With the macro defined:
  - Adds port mask, input, width 2^N, where 1 = skip that line.
  - In SCAN, an advance moves to the next unmasked index in increasing order, wrapping modulo 2^N. wrap pulses whenever the search passes through index 0.
  - SCAN entry starts at the lowest unmasked index.
  - If all lines are masked, D=0 and idx holds.
  - Direct mode ignores mask.
- Without the macro: the port is absent and every line is scanned.

Test Plan:
- Reset and direct decode: with N=2, assert rst mid-stream, then release and set en=1, mode=0, A=0,1,2,3 on consecutive cycles.
  - During reset: D=0000 immediately, idx=0.
  - After release: D=0001,0010,0100,1000, each one cycle after its A.
- Scan at dwell 2: load dwell=2, then en=1, mode=1.
  - D steps 0001→0010→0100→1000→0001, each line held 3 cycles.
  - wrap=1 for exactly the single cycle in which D returns to 0001.
- Scan at dwell 0: load dwell=0.
  - D advances every cycle, and wrap pulses every 4 cycles.
  - Drop en for 1 cycle: D=0000, and the scan restarts at 0001.
- Load collision: load dwell=5 in the cycle where cnt == dwell_reg.
  - No advance on that edge; the current line is held for 6 further cycles.
- Mode switch: mid-scan at D=0100, set mode=0 with A=3.
  - Next edge: D=1000.
  - Return to mode=1: the next edge gives D=0001 and idx=0.
- DECODER_SCAN_MASK_EN: with N=2, mask=0101, dwell=0.
  - D alternates 0010, 1000, with wrap on each 1000→0010 transition.
  - Set mask=1111: D=0000 and idx holds.

Source files
------------

// File: rtl/decoder_nto2n_scan.sv
// N-to-2^N registered one-hot decoder with dwell-timed auto-scan; `DECODER_SCAN_MASK_EN adds a line-skip mask.
// Latency: 1 cycle from inputs to D/idx/wrap; no backpressure, lines change only on en/mode/A/dwell timing.
module decoder_nto2n_scan #(
  parameter int N         = 2,
  parameter int DWELL_W   = 8,
  parameter int DWELL_RST = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic [N-1:0]       A,
  input  logic               load,
  input  logic [DWELL_W-1:0] dwell,
`ifdef DECODER_SCAN_MASK_EN
  input  logic [(1<<N)-1:0]  mask,
`endif
  output logic [(1<<N)-1:0]  D,
  output logic [N-1:0]       idx,
  output logic               wrap
);

  localparam int L = 1 << N;

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

  state_t             r_state, w_state_nxt;
  logic [L-1:0]       r_d, w_d_nxt;
  logic [N-1:0]       r_idx, w_idx_nxt;
  logic               r_wrap, w_wrap_nxt;
  logic [DWELL_W-1:0] r_cnt, w_cnt_nxt;
  logic [DWELL_W-1:0] r_dwell, w_dwell_nxt;

  logic [L-1:0]       w_one;
  logic [N-1:0]       w_adv_idx;
  logic               w_adv_found;
  logic               w_adv_wrap;
  logic [N-1:0]       w_first_idx;
  logic               w_first_found;

  assign w_one = {{(L-1){1'b0}}, 1'b1};

`ifdef DECODER_SCAN_MASK_EN
  // Next unmasked line strictly after r_idx; a carry out of the N-bit index means we crossed line 0.
  always_comb begin
    logic [N:0] w_sum;
    w_adv_idx   = r_idx;
    w_adv_found = 1'b0;
    w_adv_wrap  = 1'b0;
    w_sum       = '0;
    for (int k = 1; k <= L; k++) begin
      w_sum = {1'b0, r_idx} + k[N:0];
      if (!w_adv_found && !mask[w_sum[N-1:0]]) begin
        w_adv_found = 1'b1;
        w_adv_idx   = w_sum[N-1:0];
        w_adv_wrap  = w_sum[N];
      end
    end
  end

  always_comb begin
    w_first_idx   = r_idx;
    w_first_found = 1'b0;
    for (int k = L - 1; k >= 0; k--) begin
      if (!mask[k]) begin
        w_first_found = 1'b1;
        w_first_idx   = k[N-1:0];
      end
    end
  end
`else
  assign w_adv_idx     = r_idx + 1'b1;
  assign w_adv_found   = 1'b1;
  assign w_adv_wrap    = (r_idx == N'(L - 1));
  assign w_first_idx   = '0;
  assign w_first_found = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_d_nxt     = r_d;
    w_idx_nxt   = r_idx;
    w_wrap_nxt  = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_dwell_nxt = load ? dwell : r_dwell;

    if (!en) begin
      w_state_nxt = IDLE;
      w_d_nxt     = '0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE, DIRECT: begin
          w_cnt_nxt = '0;
          if (mode) begin
            // Scan always restarts from the first eligible line.
            w_state_nxt = SCAN;
            if (w_first_found) begin
              w_idx_nxt = w_first_idx;
              w_d_nxt   = w_one << w_first_idx;
            end else begin
              w_d_nxt   = '0;
            end
          end else begin
            w_state_nxt = DIRECT;
            w_idx_nxt   = A;
            w_d_nxt     = w_one << A;
          end
        end
        SCAN: begin
          if (!mode) begin
            w_state_nxt = DIRECT;
            w_cnt_nxt   = '0;
            w_idx_nxt   = A;
            w_d_nxt     = w_one << A;
          end else if (load) begin
            w_cnt_nxt = '0;
          end else if (r_cnt == r_dwell) begin
            w_cnt_nxt = '0;
            if (w_adv_found) begin
              w_idx_nxt  = w_adv_idx;
              w_d_nxt    = w_one << w_adv_idx;
              w_wrap_nxt = w_adv_wrap;
            end else begin
              w_d_nxt    = '0;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_d_nxt     = '0;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d     <= '0;
      r_idx   <= '0;
      r_wrap  <= 1'b0;
      r_cnt   <= '0;
      r_dwell <= DWELL_W'(DWELL_RST);
    end else begin
      r_d     <= w_d_nxt;
      r_idx   <= w_idx_nxt;
      r_wrap  <= w_wrap_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dwell <= w_dwell_nxt;
    end
  end

  assign D    = r_d;
  assign idx  = r_idx;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_decoder_nto2n_scan.sv
// Directed bench for decoder_nto2n_scan at N=2: reset, direct decode, dwell scan, load collision, mode switch, mask.
module tb_decoder_nto2n_scan;

  localparam int N  = 2;
  localparam int L  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          mode;
  logic [N-1:0]  A;
  logic          load;
  logic [DW-1:0] dwell;
  logic [L-1:0]  mask;
  logic [L-1:0]  D;
  logic [N-1:0]  idx;
  logic          wrap;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  decoder_nto2n_scan #(.N(N), .DWELL_W(DW), .DWELL_RST(0)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .mode  (mode),
    .A     (A),
    .load  (load),
    .dwell (dwell),
`ifdef DECODER_SCAN_MASK_EN
    .mask  (mask),
`endif
    .D     (D),
    .idx   (idx),
    .wrap  (wrap)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    logic [L-1:0] dir_d  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [L-1:0] dw0_d  [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001,
                                  4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic         dw0_w  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; en = 1'b0; mode = 1'b0; A = '0; load = 1'b0; dwell = '0; mask = '0;
    tick(); tick();
    check("rst_D", 32'(D), 32'h0);
    check("rst_idx", 32'(idx), 32'h0);
    check("rst_wrap", 32'(wrap), 32'h0);

    // Direct traffic, then reset asserted between edges.
    rst = 1'b0; en = 1'b1; mode = 1'b0; A = 2'd2;
    tick();
    check("pre_rst_D", 32'(D), 32'h4);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_D", 32'(D), 32'h0);
    check("async_rst_idx", 32'(idx), 32'h0);
    tick();
    rst = 1'b0;

    for (int a = 0; a < 4; a++) begin
      A = a[N-1:0];
      tick();
      check("direct_D", 32'(D), 32'(dir_d[a]));
      check("direct_idx", 32'(idx), a);
    end

    // Scan at dwell 2: three samples per line, wrap only on the return to line 0.
    en = 1'b0; load = 1'b1; dwell = 8'd2;
    tick();
    check("idle_D", 32'(D), 32'h0);
    load = 1'b0; en = 1'b1; mode = 1'b1;
    for (int c = 0; c < 14; c++) begin
      tick();
      check("dw2_D", 32'(D), 32'(dir_d[(c / 3) % 4]));
      check("dw2_idx", 32'(idx), (c / 3) % 4);
      check("dw2_wrap", 32'(wrap), (c == 12) ? 32'h1 : 32'h0);
    end

    // Dwell 0: load edge holds the line, then one line per cycle.
    load = 1'b1; dwell = 8'd0;
    tick();
    check("dw0_load_D", 32'(D), 32'h1);
    load = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("dw0_D", 32'(D), 32'(dw0_d[k]));
      check("dw0_wrap", 32'(wrap), 32'(dw0_w[k]));
    end

    en = 1'b0;
    tick();
    check("en_drop_D", 32'(D), 32'h0);
    check("en_drop_wrap", 32'(wrap), 32'h0);
    en = 1'b1;
    tick();
    check("rescan_D", 32'(D), 32'h1);
    check("rescan_idx", 32'(idx), 32'h0);

    // cnt == dwell_reg (0) here: load must win over the advance.
    load = 1'b1; dwell = 8'd5;
    tick();
    check("coll_load_D", 32'(D), 32'h1);
    load = 1'b0;
    A = 2'd3;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("coll_D", 32'(D), (k < 5) ? 32'h1 : 32'h2);
    end

    // Mode switch from D=0100 to direct A=3 and back.
    load = 1'b1; dwell = 8'd0;
    tick();
    check("ms_load_D", 32'(D), 32'h2);
    load = 1'b0;
    tick();
    check("ms_scan_D", 32'(D), 32'h4);
    check("ms_scan_idx", 32'(idx), 32'h2);
    mode = 1'b0; A = 2'd3;
    tick();
    check("ms_direct_D", 32'(D), 32'h8);
    check("ms_direct_idx", 32'(idx), 32'h3);
    mode = 1'b1;
    tick();
    check("ms_back_D", 32'(D), 32'h1);
    check("ms_back_idx", 32'(idx), 32'h0);
    tick();
    check("ms_ign_A_D", 32'(D), 32'h2);

`ifdef DECODER_SCAN_MASK_EN
    mask = 4'b0101;
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    check("mask_entry_D", 32'(D), 32'h2);
    check("mask_entry_wrap", 32'(wrap), 32'h0);
    tick();
    check("mask_D1", 32'(D), 32'h8);
    check("mask_w1", 32'(wrap), 32'h0);
    tick();
    check("mask_D2", 32'(D), 32'h2);
    check("mask_w2", 32'(wrap), 32'h1);
    tick();
    check("mask_D3", 32'(D), 32'h8);
    check("mask_w3", 32'(wrap), 32'h0);
    tick();
    check("mask_D4", 32'(D), 32'h2);
    check("mask_w4", 32'(wrap), 32'h1);
    mask = 4'b1111;
    tick();
    check("mask_all_D", 32'(D), 32'h0);
    check("mask_all_idx", 32'(idx), 32'h1);
    tick();
    check("mask_all_D2", 32'(D), 32'h0);
    check("mask_all_idx2", 32'(idx), 32'h1);
    check("mask_all_wrap", 32'(wrap), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
